// File: rtl/intra_edge_filter.sv
// -----------------------------------------------------------------------------
// intra_edge_filter
//
// Smoothing stage for AV1 intra edge pixels. A job captures a run of reference
// edge pixels (corner first, then the edge), applies the 5-tap AV1 edge kernel
// selected by strength, and streams the filtered edge out with valid/ready.
// Element 0 (the corner) always passes through unfiltered.
//
// Parameters
//   PX_W   : pixel bit width
//   MAX_PX : edge buffer capacity in pixels (corner included)
//   CNT_W  : width of count/index fields, 2^CNT_W > MAX_PX
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, strength,    : job request (sampled in IDLE only), kernel select,
//   num_px              :   edge length including the corner
//   busy                : high whenever the FSM is not IDLE
//   in_valid, in_ready,  : input pixel stream (ready only while loading)
//   in_px
//   out_valid, out_ready,: filtered output stream, out_last on index n-1
//   out_px, out_last
//   done                : one-cycle pulse after the final output handshake
// -----------------------------------------------------------------------------
module intra_edge_filter #(
  parameter int PX_W   = 10,
  parameter int MAX_PX = 33,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       strength,
  input  logic [CNT_W-1:0] num_px,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PX_W-1:0]  in_px,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PX_W-1:0]  out_px,
  output logic             out_last,
  output logic             done
);

  localparam int ACC_W = PX_W + 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [1:0]       strength_r;
  logic [CNT_W-1:0] n_r;
  logic [CNT_W-1:0] idx_r;
  logic [PX_W-1:0]  buf_r [MAX_PX];

  logic             busy_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [PX_W-1:0]  out_px_r;
  logic             out_last_r;
  logic             done_r;

  logic             in_hs_s;
  logic             out_hs_s;
  logic             start_ok_s;
  logic [CNT_W-1:0] n_eff_s;
  logic             at_end_s;
  logic             load_last_s;
  logic             emit_last_s;
  logic [CNT_W-1:0] next_idx_s;
  logic [ACC_W-1:0] acc_s;
  logic [ACC_W-1:0] sum_s;
  logic [CNT_W-1:0] center_s;
  logic [PX_W-1:0]  filt_s;

  // Kernel coefficient for tap j of the given strength; strength 0 is handled
  // as a pass-through elsewhere, so its taps are all zero here.
  function automatic logic [3:0] kernel_coef(input logic [1:0] s, input logic [2:0] j);
    logic [3:0] c;
    c = 4'd0;
    case (s)
      2'd1: begin
        case (j)
          3'd1:    c = 4'd4;
          3'd2:    c = 4'd8;
          3'd3:    c = 4'd4;
          default: c = 4'd0;
        endcase
      end
      2'd2: begin
        case (j)
          3'd1:    c = 4'd5;
          3'd2:    c = 4'd6;
          3'd3:    c = 4'd5;
          default: c = 4'd0;
        endcase
      end
      2'd3: begin
        case (j)
          3'd0:    c = 4'd2;
          3'd1:    c = 4'd4;
          3'd2:    c = 4'd4;
          3'd3:    c = 4'd4;
          3'd4:    c = 4'd2;
          default: c = 4'd0;
        endcase
      end
      default: c = 4'd0;
    endcase
    return c;
  endfunction

  assign in_hs_s     = in_valid & in_ready_r;
  assign out_hs_s    = out_valid_r & out_ready;
  assign start_ok_s  = start & (num_px != {CNT_W{1'b0}});
  assign n_eff_s     = (num_px > CNT_W'(MAX_PX)) ? CNT_W'(MAX_PX) : num_px;
  assign at_end_s    = (idx_r == (n_r - CNT_W'(1)));
  assign load_last_s = (state_r == LOAD) & in_hs_s & at_end_s;
  assign emit_last_s = (state_r == EMIT) & out_hs_s & at_end_s;
  assign next_idx_s  = idx_r + CNT_W'(1);

  // Next-state logic for the IDLE -> LOAD -> EMIT -> IDLE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (load_last_s) begin
          state_s = EMIT;
        end else begin
          state_s = LOAD;
        end
      end
      EMIT: begin
        if (emit_last_s) begin
          state_s = IDLE;
        end else begin
          state_s = EMIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // 5-tap filter for the pixel that follows the one currently presented.
  // Tap positions are clamped to [0, n-1], which also keeps every buffer
  // read in range when the last pixel is on the output.
  always_comb begin
    int pos;
    logic [CNT_W-1:0] tap;
    acc_s    = {ACC_W{1'b0}};
    center_s = {CNT_W{1'b0}};
    for (int j = 0; j < 5; j++) begin
      pos = int'(next_idx_s) - 32'sd2 + j;
      if (pos < 32'sd0) begin
        pos = 32'sd0;
      end else if (pos > (int'(n_r) - 32'sd1)) begin
        pos = int'(n_r) - 32'sd1;
      end else begin
        pos = pos;
      end
      tap = CNT_W'(pos);
      if (j == 2) begin
        center_s = tap;
      end else begin
        center_s = center_s;
      end
      acc_s = acc_s + ACC_W'(kernel_coef(strength_r, 3'(j))) * ACC_W'(buf_r[tap]);
    end
    // Taps sum to 16, so the rounded result always fits in PX_W bits.
    sum_s = acc_s + ACC_W'(8);
    if (strength_r == 2'd0) begin
      filt_s = buf_r[center_s];
    end else begin
      filt_s = sum_s[ACC_W-1:4];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Job parameters and the shared load/emit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strength_r <= 2'd0;
      n_r        <= {CNT_W{1'b0}};
      idx_r      <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            strength_r <= strength;
            n_r        <= n_eff_s;
            idx_r      <= {CNT_W{1'b0}};
          end else begin
            idx_r <= idx_r;
          end
        end
        LOAD: begin
          if (in_hs_s) begin
            idx_r <= at_end_s ? {CNT_W{1'b0}} : next_idx_s;
          end else begin
            idx_r <= idx_r;
          end
        end
        EMIT: begin
          if (out_hs_s) begin
            idx_r <= at_end_s ? {CNT_W{1'b0}} : next_idx_s;
          end else begin
            idx_r <= idx_r;
          end
        end
        default: idx_r <= {CNT_W{1'b0}};
      endcase
    end
  end

  // Edge buffer; contents are don't-care after reset, so it has none.
  always_ff @(posedge clk) begin
    if (in_hs_s) begin
      buf_r[idx_r] <= in_px;
    end else begin
      buf_r[idx_r] <= buf_r[idx_r];
    end
  end

  // Registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_px_r    <= {PX_W{1'b0}};
      out_last_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      busy_r     <= (state_s != IDLE);
      in_ready_r <= (state_s == LOAD);
      done_r     <= emit_last_s;
      if (load_last_s) begin
        // Corner goes out first; for a one-pixel edge it is the pixel
        // arriving in this very handshake.
        out_valid_r <= 1'b1;
        out_px_r    <= (n_r == CNT_W'(1)) ? in_px : buf_r[0];
        out_last_r  <= (n_r == CNT_W'(1));
      end else if ((state_r == EMIT) && out_hs_s) begin
        if (at_end_s) begin
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end else begin
          out_px_r   <= filt_s;
          out_last_r <= (next_idx_s == (n_r - CNT_W'(1)));
        end
      end else begin
        out_valid_r <= out_valid_r;
        out_px_r    <= out_px_r;
        out_last_r  <= out_last_r;
      end
    end
  end

  assign busy      = busy_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_px    = out_px_r;
  assign out_last  = out_last_r;
  assign done      = done_r;

endmodule

// File: tb/tb_intra_edge_filter.sv
// -----------------------------------------------------------------------------
// Directed testbench for intra_edge_filter. Each test task loads its pixels
// and hand-computed expected outputs, runs a job through run_job (which only
// drives and captures) and compares the captured results inline.
// -----------------------------------------------------------------------------
module tb_intra_edge_filter;
  localparam int PX_W   = 10;
  localparam int MAX_PX = 33;
  localparam int CNT_W  = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       strength = 2'd0;
  logic [CNT_W-1:0] num_px = '0;
  logic             busy;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PX_W-1:0]  in_px = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [PX_W-1:0]  out_px;
  logic             out_last;
  logic             done;

  int checks = 0;
  int errors = 0;

  int in_pix [64];
  int exp_px [64];
  int got    [64];
  bit got_last [64];
  int gn, accepted, edges, stall_err;
  bit timed_out, done_ok, done_after_ok;

  intra_edge_filter #(.PX_W(PX_W), .MAX_PX(MAX_PX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .strength(strength),
    .num_px(num_px), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_px(in_px), .out_valid(out_valid), .out_ready(out_ready),
    .out_px(out_px), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic set5(input int a, input int b, input int c, input int d, input int e);
    in_pix[0] = a; in_pix[1] = b; in_pix[2] = c; in_pix[3] = d; in_pix[4] = e;
  endtask

  task automatic exp5(input int a, input int b, input int c, input int d, input int e);
    exp_px[0] = a; exp_px[1] = b; exp_px[2] = c; exp_px[3] = d; exp_px[4] = e;
  endtask

  // Drive one job and capture everything; called at posedge+1.
  task automatic run_job(input logic [1:0] s, input int np, input bit gaps, input bit poke);
    bit finished, stalled, held_last;
    int held_px;
    gn = 0; accepted = 0; edges = 0; stall_err = 0;
    timed_out = 1'b0; done_ok = 1'b0; done_after_ok = 1'b0;
    finished = 1'b0; stalled = 1'b0; held_px = 0; held_last = 1'b0;
    start = 1'b1; strength = s; num_px = CNT_W'(np);
    @(posedge clk); #1; edges = 1; start = 1'b0;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      if (stalled && (out_px !== PX_W'(held_px) || out_last !== held_last)) stall_err++;
      stalled   = 1'b0;
      in_valid  = (accepted < np) && (!gaps || $urandom_range(0, 1) == 1);
      in_px     = PX_W'(in_pix[accepted]);
      out_ready = !gaps || ($urandom_range(0, 2) != 0);
      start     = poke && busy && (cyc % 4 == 1);
      if (poke) begin num_px = 6'd3; strength = 2'd0; end
      if (in_valid && in_ready) accepted++;
      if (out_valid && out_ready) begin
        if (gn < 64) begin got[gn] = int'(out_px); got_last[gn] = out_last; end
        gn++;
        if (out_last) finished = 1'b1;
      end else if (out_valid) begin
        stalled = 1'b1; held_px = int'(out_px); held_last = out_last;
      end
      @(posedge clk); #1; edges++;
    end
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
    if (!finished) begin
      timed_out = 1'b1;
    end else begin
      done_ok = (done === 1'b1) && (busy === 1'b0) && (out_valid === 1'b0);
      @(posedge clk); #1;
      done_after_ok = (done === 1'b0) && (busy === 1'b0);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({busy, in_ready, out_valid, out_last, done} !== 5'b0 || out_px !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b in_ready=%b out_valid=%b out_last=%b done=%b out_px=%0d, required all 0",
               busy, in_ready, out_valid, out_last, done, out_px);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: busy=%b out_valid=%b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_strength1;
    set5(150, 15, 50, 23, 4); exp5(150, 58, 35, 25, 9);
    run_job(2'd1, 5, 1'b0, 1'b0);
    checks++;
    if (timed_out || gn != 5) begin errors++; $display("FAIL s1_count: got %0d outputs timeout=%0b, required 5", gn, timed_out); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] != exp_px[i] || got_last[i] != (i == 4)) begin
        errors++; $display("FAIL s1_px[%0d]: got %0d last=%0b, required %0d last=%0b", i, got[i], got_last[i], exp_px[i], i == 4);
      end
    end
    checks++;
    if (!done_ok || !done_after_ok) begin errors++; $display("FAIL s1_done: pulse=%0b after=%0b, required 1 1", done_ok, done_after_ok); end
    checks++;
    if (edges != 11) begin errors++; $display("FAIL s1_latency: got %0d cycles, required 11", edges); end
  endtask

  task automatic test_strength3_clamp;
    set5(150, 15, 50, 23, 4); exp5(150, 75, 41, 22, 15);
    run_job(2'd3, 5, 1'b0, 1'b0);
    checks++;
    if (timed_out || gn != 5) begin errors++; $display("FAIL s3_count: got %0d outputs, required 5", gn); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] != exp_px[i]) begin errors++; $display("FAIL s3_px[%0d]: got %0d, required %0d", i, got[i], exp_px[i]); end
    end
  endtask

  task automatic test_strength0;
    for (int i = 0; i < 8; i++) in_pix[i] = (i % 4 == 0) ? 15 : (i % 4 == 1) ? 50 : (i % 4 == 2) ? 23 : 4;
    run_job(2'd0, 8, 1'b0, 1'b0);
    checks++;
    if (timed_out || gn != 8) begin errors++; $display("FAIL s0_count: got %0d outputs, required 8", gn); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] != in_pix[i] || got_last[i] != (i == 7)) begin
        errors++; $display("FAIL s0_px[%0d]: got %0d last=%0b, required %0d", i, got[i], got_last[i], in_pix[i]);
      end
    end
    checks++;
    if (edges != 17) begin errors++; $display("FAIL s0_latency: got %0d cycles, required 17", edges); end
  endtask

  task automatic test_min_len;
    in_pix[0] = 777;
    run_job(2'd1, 1, 1'b0, 1'b0);
    checks++;
    if (timed_out || gn != 1 || got[0] != 777 || got_last[0] != 1'b1) begin
      errors++; $display("FAIL min_len: got n=%0d px=%0d last=%0b, required n=1 px=777 last=1", gn, got[0], got_last[0]);
    end
    checks++;
    if (!done_ok || edges != 3) begin errors++; $display("FAIL min_len_done: pulse=%0b cycles=%0d, required 1 3", done_ok, edges); end
  endtask

  task automatic test_saturation;
    int bad;
    for (int i = 0; i < MAX_PX; i++) in_pix[i] = 1023;
    run_job(2'd2, MAX_PX, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < MAX_PX; i++) if (got[i] != 1023) bad++;
    checks++;
    if (timed_out || gn != MAX_PX || bad != 0) begin
      errors++; $display("FAIL saturation: got n=%0d wrong=%0d first=%0d, required n=33 all 1023", gn, bad, got[0]);
    end
  endtask

  task automatic test_capacity;
    int bad;
    for (int i = 0; i < 40; i++) in_pix[i] = i * 7 + 3;
    run_job(2'd0, 40, 1'b0, 1'b0);
    checks++;
    if (accepted != MAX_PX) begin errors++; $display("FAIL cap_accepted: got %0d pixels accepted, required 33", accepted); end
    bad = 0;
    for (int i = 0; i < MAX_PX; i++) if (got[i] != in_pix[i] || got_last[i] != (i == MAX_PX - 1)) bad++;
    checks++;
    if (timed_out || gn != MAX_PX || bad != 0) begin
      errors++; $display("FAIL cap_output: got n=%0d wrong=%0d, required n=33 wrong=0", gn, bad);
    end
  endtask

  task automatic test_stalls;
    set5(150, 15, 50, 23, 4); exp5(150, 58, 35, 25, 9);
    run_job(2'd1, 5, 1'b1, 1'b1);
    checks++;
    if (timed_out || gn != 5) begin errors++; $display("FAIL stall_count: got %0d outputs, required 5", gn); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] != exp_px[i]) begin errors++; $display("FAIL stall_px[%0d]: got %0d, required %0d", i, got[i], exp_px[i]); end
    end
    checks++;
    if (stall_err != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles, required 0", stall_err); end
    checks++;
    if (!done_ok || !done_after_ok || busy !== 1'b0) begin
      errors++; $display("FAIL stall_ignored_start: pulse=%0b after=%0b busy=%b, required 1 1 0", done_ok, done_after_ok, busy);
    end
  endtask

  task automatic test_mid_reset;
    int bad;
    set5(150, 15, 50, 23, 4);
    start = 1'b1; strength = 2'd1; num_px = 6'd5;
    @(posedge clk); #1; start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin in_px = PX_W'(in_pix[i]); @(posedge clk); #1; end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1'b0; #1;
    checks++;
    if ({busy, in_ready, out_valid, out_last, done} !== 5'b0 || out_px !== '0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b in_ready=%b out_valid=%b out_last=%b done=%b out_px=%0d, required all 0",
               busy, in_ready, out_valid, out_last, done, out_px);
    end
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (out_valid !== 1'b0 || busy !== 1'b0) bad++; end
    out_ready = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL post_reset_idle: got %0d active cycles, required 0", bad); end
    exp5(150, 75, 41, 22, 15);
    run_job(2'd3, 5, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 5; i++) if (got[i] != exp_px[i]) bad++;
    checks++;
    if (timed_out || gn != 5 || bad != 0) begin errors++; $display("FAIL post_reset_job: got n=%0d wrong=%0d, required n=5 wrong=0", gn, bad); end
  endtask

  task automatic test_zero_len;
    start = 1'b1; strength = 2'd1; num_px = 6'd0;
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL zero_len: busy=%b in_ready=%b, required 0 0", busy, in_ready); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_len_hold: busy=%b, required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_strength1();
    test_strength3_clamp();
    test_strength0();
    test_min_len();
    test_saturation();
    test_capacity();
    test_stalls();
    test_mid_reset();
    test_zero_len();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intra_edge_filter.md
# intra_edge_filter

Smoothing stage for AV1 intra edge pixels, sitting directly upstream of `intra_edge_upsample`. It captures a run of reference edge pixels (above-left corner followed by the left or above edge) and applies the AV1 5-tap edge kernel selected by `strength`. It then streams the filtered edge out with a valid/ready handshake. Edge element 0 (the corner pixel) passes through unfiltered, so the output can feed the upsampler's `referencePixel` and `input_array` directly.

## Interface
- `PX_W`, default 10, pixel bit width.
- `MAX_PX`, default 33, capacity of the edge buffer in pixels (corner included).
- `CNT_W`, default 6, width of count and index fields; must satisfy 2^CNT_W > MAX_PX.
- `clk`, in, 1, the single clock; all state is updated on its rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `start`, in, 1, request to begin a job; sampled only in IDLE.
- `strength`, in, 2, kernel select, sampled with `start`.
- `num_px`, in, CNT_W, edge length including the corner, sampled with `start`.
- `busy`, out, 1, high in every state except IDLE.
- `in_valid`, in, 1, input pixel valid.
- `in_ready`, out, 1, high only in LOAD.
- `in_px`, in, PX_W, input pixel; the first pixel of a job is the corner.
- `out_valid`, out, 1, output pixel valid.
- `out_ready`, in, 1, downstream accepts the output pixel.
- `out_px`, out, PX_W, filtered pixel.
- `out_last`, out, 1, marks the final pixel of the job (index num_px-1).
- `done`, out, 1, one-cycle pulse after the final output handshake.

## Operation
- **FSM states:** IDLE → LOAD → EMIT → IDLE.
- **IDLE:**
  - On `start=1`, latch `strength` and the effective length `n`, clear the index, and go to LOAD.
  - `n = min(num_px, MAX_PX)`.
  - If `num_px == 0`, ignore `start` and stay in IDLE.
  - `start` is ignored in every state other than IDLE.
- **LOAD:**
  - Each `in_valid & in_ready` writes `in_px` to `buf[idx]` and increments `idx`.
  - The handshake that writes `buf[n-1]` moves the FSM to EMIT and resets `idx` to 0.
- **EMIT:**
  - Output `i` goes out for i = 0..n-1, one per `out_valid & out_ready` handshake.
  - The final handshake moves the FSM to IDLE.
- **Kernels** (indexed j = 0..4):
  - strength 1: {0,4,8,4,0}
  - strength 2: {0,5,6,5,0}
  - strength 3: {2,4,4,4,2}
- **Filtered value:** `out[i] = (Σ_j K[j]·buf[clamp(i-2+j, 0, n-1)] + 8) >> 4` for i ≥ 1.
- **Pass-through cases:**
  - `out[0] = buf[0]` always.
  - strength 0: `out[i] = buf[i]` for all i.
  - n = 1: the single pixel passes through.
- **Arithmetic:**
  - Unsigned accumulator of PX_W+4 bits.
  - Kernel taps sum to 16, so the result never exceeds 2^PX_W−1; no clamping is needed.
  - Filtering always reads the unmodified input buffer (no in-place update).

## Timing
- **Reset values:**
  - State = IDLE.
  - `busy`, `in_ready`, `out_valid`, `out_last`, and `done` are all 0.
  - `out_px` = 0, and `idx` = 0.
  - Buffer contents are don't-care.
- **Start:** `start` accepted at cycle t gives `busy=1` and `in_ready=1` from cycle t+1.
- **LOAD throughput:** one pixel per cycle; `in_valid` low stalls without penalty.
- **LOAD → EMIT:**
  - If the final input handshake occurs at cycle t, then `in_ready=0` and `out_valid=1` with `out_px=out[0]` from cycle t+1.
  - `out_px` is registered.
- **EMIT throughput:** one pixel per cycle while `out_ready=1`.
- **Stall stability:** while `out_valid & !out_ready`, `out_px` and `out_last` hold stable.
- **Final output:**
  - `out_last=1` is asserted together with `out[n-1]`.
  - If the final handshake occurs at cycle t, then at t+1: `out_valid=0`, `done=1` for exactly one cycle, `busy=0`, and the FSM is in IDLE.
  - A new `start` is accepted at t+1.
- **Latency:** a job of n pixels with no stalls occupies 1 + n + n cycles from `start` to the `done` pulse.
- **Reset mid-job:** asynchronously abandons the job; no partial output is emitted after reset release.

## Test plan
- **Strength 1:** num_px=5, pixels [150,15,50,23,4], `out_ready=1` → out [150,58,35,25,9]; `out_last` on 9; `done` one cycle after.
- **Strength 3, with clamping:** same pixels → out [150,75,41,22,15], which exercises edge clamping at both ends.
- **Strength 0 and minimum length:**
  - strength 0, num_px=8, pixels [15,50,23,4,15,50,23,4] → identical output.
  - num_px=1 → single pass-through pixel with `out_last=1`.
- **Saturation and capacity:**
  - strength 2, num_px=MAX_PX, all pixels 1023 → all outputs 1023 (no overflow).
  - num_px=40 → exactly MAX_PX pixels accepted.
- **Handshake stalls and ignored start:**
  - Random `in_valid` and `out_ready` gaps → same data as the no-stall run.
  - `out_px` held stable through every stall.
  - `start` pulsed during LOAD/EMIT is ignored.
- **Reset and zero length:**
  - `rst_n` low mid-EMIT → all outputs 0 immediately; a subsequent job runs correctly.
  - `start` with num_px=0 → `busy` stays 0.
